// File: rtl/bp_update_sched.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// bp_update_sched
//
// Buffers committed branch-predictor updates and writes them into the
// single-ported BTB/BPB arrays in cycles where fetch is not using the port.
// A starvation counter forces a one-cycle fetch bubble, so updates can never
// be deferred indefinitely.
//
// Optional build macro: BP_UPD_COALESCE_EN
//   Defined   : a push whose PC matches the newest buffered entry overwrites
//               that entry in place (target/direction/type) instead of
//               allocating a new one.
//   Undefined : every accepted push allocates a new entry.
//
// Ports:
//   clk           in   clock, all state updates on rising edge
//   reset         in   asynchronous reset, active-low
//   upd_valid_i   in   committed update offered
//   upd_pc_i      in   branch PC
//   upd_tar_i     in   resolved target
//   upd_dir_i     in   resolved direction
//   upd_type_i    in   control type
//   upd_hold_o    out  buffer full, upstream must hold its head entry
//   fetch_req_i   in   fetch wants the array port this cycle
//   fetch_block_o out  forced fetch bubble this cycle
//   wr_en_o       out  array write this cycle
//   wr_pc_o       out  write PC
//   wr_tar_o      out  write target
//   wr_dir_o      out  write direction
//   wr_type_o     out  write type
//   pending_o     out  buffer occupancy
// ---------------------------------------------------------------------------
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef BRANCH_TYPE
`define BRANCH_TYPE 2
`endif

module bp_update_sched #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8,
   parameter int PC_W         = `SIZE_PC,
   parameter int BT_W         = `BRANCH_TYPE
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     upd_valid_i,
   input  logic [PC_W-1:0]          upd_pc_i,
   input  logic [PC_W-1:0]          upd_tar_i,
   input  logic                     upd_dir_i,
   input  logic [BT_W-1:0]          upd_type_i,
   output logic                     upd_hold_o,
   input  logic                     fetch_req_i,
   output logic                     fetch_block_o,
   output logic                     wr_en_o,
   output logic [PC_W-1:0]          wr_pc_o,
   output logic [PC_W-1:0]          wr_tar_o,
   output logic                     wr_dir_o,
   output logic [BT_W-1:0]          wr_type_o,
   output logic [$clog2(DEPTH):0]   pending_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FORCE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   head_q, head_d;
   logic [AW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [SW-1:0]   starve_q, starve_d;

   // Entry storage; no reset needed, validity is carried by count_q.
   logic [PC_W-1:0] pc_q   [DEPTH];
   logic [PC_W-1:0] tar_q  [DEPTH];
   logic            dir_q  [DEPTH];
   logic [BT_W-1:0] type_q [DEPTH];

   logic             full;
   logic             empty;
   logic             grant;
   logic             coalesce;
   logic             alloc;
   logic [DEPTH-1:0] alloc_sel;
   logic [DEPTH-1:0] coal_sel;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // FORCE always wins the port; otherwise updates use only idle fetch cycles.
   assign grant = !empty && ((state_q == FORCE) || !fetch_req_i);

`ifdef BP_UPD_COALESCE_EN
   logic [AW-1:0] newest_idx;
   assign newest_idx = tail_q - AW'(1);
   // The newest entry cannot be merged into while it is leaving the buffer.
   assign coalesce = upd_valid_i && !empty && (pc_q[newest_idx] == upd_pc_i) &&
                     !((count_q == CW'(1)) && grant);
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_coal_sel
      assign coal_sel[gi] = coalesce && (newest_idx == AW'(gi));
   end
`else
   assign coalesce = 1'b0;
   assign coal_sel = '0;
`endif

   // A push while full is dropped (protocol violation) unless it merges.
   assign alloc = upd_valid_i && !full && !coalesce;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_alloc_sel
      assign alloc_sel[gi] = alloc && (tail_q == AW'(gi));
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (alloc_sel[i]) begin
            pc_q[i] <= upd_pc_i;
         end
         if (alloc_sel[i] || coal_sel[i]) begin
            tar_q[i]  <= upd_tar_i;
            dir_q[i]  <= upd_dir_i;
            type_q[i] <= upd_type_i;
         end
      end
   end

   // Pointer and occupancy next state.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CW'(alloc) - CW'(grant);
      if (grant) begin
         head_d = head_q + AW'(1);
      end
      if (alloc) begin
         tail_d = tail_q + AW'(1);
      end
   end

   // Starvation counter: counts consecutive denied cycles while work is
   // pending. It wraps to zero on the transition into FORCE, whose
   // unconditional grant would clear it anyway.
   always_comb begin
      starve_d = starve_q;
      if (grant || empty) begin
         starve_d = '0;
      end else if (fetch_req_i && (state_q != FORCE)) begin
         if (starve_q == SW'(STARVE_LIMIT - 1)) begin
            starve_d = '0;
         end else begin
            starve_d = starve_q + SW'(1);
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (count_d != '0) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if ((starve_q == SW'(STARVE_LIMIT - 1)) && fetch_req_i) begin
               state_d = FORCE;
            end else if (count_d == '0) begin
               state_d = IDLE;
            end
         end
         FORCE: begin
            state_d = (count_d != '0) ? WAIT : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         starve_q <= starve_d;
      end
   end

   // Outputs: hold and block decode registered state only.
   assign upd_hold_o    = full;
   assign fetch_block_o = (state_q == FORCE);
   assign pending_o     = count_q;
   assign wr_en_o       = grant;
   assign wr_pc_o       = grant ? pc_q[head_q]   : '0;
   assign wr_tar_o      = grant ? tar_q[head_q]  : '0;
   assign wr_dir_o      = grant ? dir_q[head_q]  : 1'b0;
   assign wr_type_o     = grant ? type_q[head_q] : '0;

endmodule

// File: doc/bp_update_sched.md
Name: bp_update_sched

Overview:
- Schedules committed branch-predictor updates from the control queue into the single-ported BTB/BPB arrays.
- Fetch reads those arrays on every active cycle, so updates get the port only in cycles when fetch does not request it.
- A starvation counter forces a one-cycle fetch bubble so updates cannot be deferred indefinitely.
- Sits between the control queue update outputs and the predictor array write port.

Parameters:
DEPTH, 4, update buffer entries (power of two, >=2)
STARVE_LIMIT, 8, consecutive denied cycles before a forced bubble (>=2)
PC_W, `SIZE_PC, PC and target width
BT_W, `BRANCH_TYPE, control-type width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous reset, active-low; all state cleared while low
upd_valid_i  in  1  committed update offered (control queue updateEn)
upd_pc_i  in  PC_W  branch PC
upd_tar_i  in  PC_W  resolved target
upd_dir_i  in  1  resolved direction
upd_type_i  in  BT_W  control type
upd_hold_o  out  1  buffer full; upstream must not release its head entry
fetch_req_i  in  1  fetch wants the array port this cycle
fetch_block_o  out  1  fetch must not access the arrays this cycle (forced bubble)
wr_en_o  out  1  array write this cycle
wr_pc_o  out  PC_W  write PC
wr_tar_o  out  PC_W  write target
wr_dir_o  out  1  write direction
wr_type_o  out  BT_W  write type
pending_o  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Storage: circular FIFO with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count of $clog2(DEPTH)+1 bits.
- pending_o = count.
- upd_hold_o = (count==DEPTH), decoded from registered state only; there is no combinational path from any input.
- Push: upd_valid_i && !upd_hold_o writes {pc,tar,dir,type} at tail.
- upd_valid_i while upd_hold_o is high is a protocol violation; the entry is dropped, with no state change.
- FSM states:
  - IDLE: count==0.
  - WAIT: count>0, port contended.
  - FORCE: bubble cycle.
- grant = (count>0) && (state==FORCE || !fetch_req_i).
- wr_en_o = grant. wr_* outputs = head entry (combinational from registers); they are 0 when wr_en_o is low.
- Pop on grant: head advances by one.
- No bypass: an entry pushed in cycle N can be granted at the earliest in cycle N+1.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, a push and pop cannot coincide, because hold was high.
- Starvation counter starve_cnt ($clog2(STARVE_LIMIT) bits):
  - Increments in any cycle with count>0 && fetch_req_i && state!=FORCE.
  - Cleared on any grant, and whenever count==0.
- Transitions:
  - IDLE -> WAIT when count becomes nonzero.
  - WAIT -> FORCE when starve_cnt==STARVE_LIMIT-1 and fetch_req_i is high (the STARVE_LIMIT-th consecutive denied cycle).
  - FORCE lasts exactly one cycle, then goes to WAIT if count after pop >0, else IDLE.
  - WAIT -> IDLE when the last entry pops.
- fetch_block_o = (state==FORCE); it is a registered state decode. In FORCE, the grant is unconditional, whatever the value of fetch_req_i.
- recoverFlag does not affect this block: buffered updates are committed and always drain.
- Reset values (asynchronous, reset low):
  - state=IDLE.
  - head, tail, count and starve_cnt = 0.
  - upd_hold_o=0, fetch_block_o=0, wr_en_o=0, wr_* = 0, pending_o=0.
- Reset asserted mid-operation discards all buffered entries immediately.
- Only one write per cycle; throughput is at most 1 update/cycle.

Optional Feature:
BP_UPD_COALESCE_EN
- Defined: when a push arrives with count>0 and upd_pc_i equals the PC of the newest entry (tail-1), that entry is overwritten in place with the new tar/dir/type.
  - count and tail are unchanged.
  - The push is accepted even when full (upd_hold_o = full && no coalesce possible is NOT used; hold stays full-based for timing).
  - The newest entry is excluded from coalescing if it is being popped in the same cycle (count==1 && grant); it then allocates normally.
- Undefined: every accepted push allocates a new entry.

Test Plan:
1. Reset low mid-stream with 3 entries buffered -> immediately pending_o=0, wr_en_o=0, fetch_block_o=0. After release, fetch_req_i=0 gives no writes.
2. Push PC=0x1000, tar=0x2000, dir=1 at cycle 0, fetch_req_i=0 -> wr_en_o=1 at cycle 1 with those values; pending_o returns to 0 at cycle 2.
3. One entry pending, fetch_req_i held 1, STARVE_LIMIT=8 -> no write for 8 cycles. In the 9th cycle fetch_block_o=1 and wr_en_o=1 for exactly one cycle, then the FSM returns to IDLE.
4. fetch_req_i=1, push 4 entries back-to-back -> upd_hold_o=1 after the 4th. A push offered while held is dropped: after the fetch_req_i=0 drain, exactly 4 writes occur in FIFO order with pointer wrap.
5. Full buffer, fetch_req_i=0, new push offered -> pop in the same cycle, upd_hold_o falls the next cycle, and a push then plus a pop leaves pending_o=3.
6. With BP_UPD_COALESCE_EN: two pushes of PC=0x1000 (dir 0, then 1) while fetch is busy -> pending_o=1, and the single write carries dir=1. Without the macro -> pending_o=2 and two writes.
